// File: rtl/instr_fetch_pkg.sv
// Shared constants, entry type and address helpers for the instruction fetch slice.
package instr_fetch_pkg;

    localparam int              IMEM_ADDR_W      = 32;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] pc;
        logic [31:0]            instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [IMEM_ADDR_W-1:0] word_align(input logic [IMEM_ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [IMEM_ADDR_W-1:0] next_pc(input logic [IMEM_ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush; holds fetched {pc, instr} entries and reports its fill level.
module ifetch_fifo #(
    parameter int               WIDTH      = 64,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Accept a push when a slot is free or one is vacated in the same cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != (AW+1)'(DEPTH)) || do_pop_s);
    end

    // Entry storage; reset contents define what the idle head shows.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RESET_WORD;
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and fill level; flush empties the queue without touching storage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign empty     = (count_r == '0);
    assign count     = count_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited sequential requests, in-order response buffering, redirect flush.
// Optional IFETCH_ALIGN_CHK_EN turns misaligned redirect targets into a sticky fault entry.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [IMEM_ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                     FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [IMEM_ADDR_W-1:0] imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [31:0]            imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [IMEM_ADDR_W-1:0] redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [IMEM_ADDR_W-1:0] out_pc,
    output logic                   out_misalign
);
    localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    logic [IMEM_ADDR_W-1:0] pc_r;
    logic [CW-1:0]          outstanding_r;
    logic [CW-1:0]          drop_cnt_r;
    logic [CW-1:0]          fifo_count_s;
    logic [CW:0]            credit_used_s;
    logic [IMEM_ADDR_W-1:0] redirect_pc_s;
    logic [IMEM_ADDR_W-1:0] resp_pc_s;
    logic                   req_valid_s;
    logic                   req_fire_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   fifo_empty_s;
    logic                   fault_s;
    logic                   fault_out_s;
    fetch_entry_t           push_entry_s;
    fetch_entry_t           head_entry_s;

`ifdef IFETCH_ALIGN_CHK_EN
    logic fault_r;
    logic fault_out_r;

    // Sticky misalign fault plus the single synthetic entry it presents to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r     <= 1'b0;
            fault_out_r <= 1'b0;
        end else if (redirect_valid) begin
            fault_r     <= (redirect_pc[1:0] != 2'b00);
            fault_out_r <= (redirect_pc[1:0] != 2'b00);
        end else if (fault_out_r && out_ready) begin
            fault_out_r <= 1'b0;
        end
    end

    assign redirect_pc_s = redirect_pc;
    assign fault_s       = fault_r;
    assign fault_out_s   = fault_out_r;
`else
    assign redirect_pc_s = word_align(redirect_pc);
    assign fault_s       = 1'b0;
    assign fault_out_s   = 1'b0;
`endif

    // Credits count both in-flight reads and buffered words, so a response always finds a slot.
    always_comb begin
        credit_used_s = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
        req_valid_s   = !rst && !redirect_valid && !fault_s && (credit_used_s < CREDIT_LIMIT);
        req_fire_s    = req_valid_s && imem_req_ready;
        push_s        = imem_resp_valid && (drop_cnt_r == '0) && !redirect_valid;
        pop_s         = out_ready && !fifo_empty_s && !fault_out_s;
    end

    // Oldest in-flight request sits outstanding words behind the fetch PC.
    assign resp_pc_s    = pc_r - {{(IMEM_ADDR_W-CW-2){1'b0}}, outstanding_r, 2'b00};
    assign push_entry_s = '{pc: resp_pc_s, instr: imem_resp_data};

    // Fetch PC, in-flight count and stale-response drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
        end else begin
            outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                pc_r       <= redirect_pc_s;
                drop_cnt_r <= outstanding_r - CW'(imem_resp_valid);
            end else begin
                if (req_fire_s) begin
                    pc_r <= next_pc(pc_r);
                end
                if (imem_resp_valid && (drop_cnt_r != '0)) begin
                    drop_cnt_r <= drop_cnt_r - CW'(1'b1);
                end
            end
        end
    end

    ifetch_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH      (FIFO_DEPTH),
        .RESET_WORD ({RESET_PC, NOP_INSTR})
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Decode sees the FIFO head, or the synthetic fault entry while it is pending.
    always_comb begin
        if (fault_out_s) begin
            out_pc    = pc_r;
            out_instr = NOP_INSTR;
        end else begin
            out_pc    = head_entry_s.pc;
            out_instr = head_entry_s.instr;
        end
    end

    assign out_valid      = fault_out_s || !fifo_empty_s;
    assign out_misalign   = fault_out_s;
    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;

endmodule
